// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, bubble insertion and branch flush; define HAZARD_STATS_EN for hazard counters
module id_ex_stage #(
    parameter int N = 64
`ifdef HAZARD_STATS_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         IF_ID_valid,
    input  logic [4:0]   IF_ID_rs1,
    input  logic [4:0]   IF_ID_rs2,
    input  logic [4:0]   IF_ID_rd,
    input  logic         IF_ID_useRs1,
    input  logic         IF_ID_useRs2,
    input  logic         IF_ID_regWrite,
    input  logic         IF_ID_memRead,
    input  logic         IF_ID_memWrite,
    input  logic         IF_ID_memtoReg,
    input  logic         IF_ID_aluSrc,
    input  logic         IF_ID_branch,
    input  logic [3:0]   IF_ID_aluControl,
    input  logic [N-1:0] IF_ID_readData1,
    input  logic [N-1:0] IF_ID_readData2,
    input  logic [N-1:0] IF_ID_signImm,
    input  logic [N-1:0] IF_ID_pc,
    input  logic         flush,
    input  logic         hold,
    output logic         ID_EX_valid,
    output logic [4:0]   ID_EX_rs1,
    output logic [4:0]   ID_EX_rs2,
    output logic [4:0]   ID_EX_rd,
    output logic         ID_EX_useRs1,
    output logic         ID_EX_useRs2,
    output logic         ID_EX_regWrite,
    output logic         ID_EX_memRead,
    output logic         ID_EX_memWrite,
    output logic         ID_EX_memtoReg,
    output logic         ID_EX_aluSrc,
    output logic         ID_EX_branch,
    output logic [3:0]   ID_EX_aluControl,
    output logic [N-1:0] ID_EX_readData1,
    output logic [N-1:0] ID_EX_readData2,
    output logic [N-1:0] ID_EX_signImm,
    output logic [N-1:0] ID_EX_pc,
`ifdef HAZARD_STATS_EN
    output logic [CNT_W-1:0] bubble_count,
    output logic [CNT_W-1:0] flush_count,
`endif
    output logic         stall
);
    logic w_lu;
    logic w_load;
    logic w_bub;

    // load-use detection; XZR never hazards, and a reset pipeline never stalls
    always_comb begin
        w_lu = ID_EX_valid & ID_EX_memRead & (ID_EX_rd != 5'd31) & IF_ID_valid &
               ((IF_ID_useRs1 & (IF_ID_rs1 == ID_EX_rd)) | (IF_ID_useRs2 & (IF_ID_rs2 == ID_EX_rd)));
        stall  = reset_n & (w_lu | hold) & ~flush;
        w_load = flush | ~hold;
        w_bub  = flush | w_lu | ~IF_ID_valid;
    end

    // pipeline register: flush > hold > load-use bubble > capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ID_EX_valid      <= 1'b0;
            ID_EX_rs1        <= '0;
            ID_EX_rs2        <= '0;
            ID_EX_rd         <= '0;
            ID_EX_useRs1     <= 1'b0;
            ID_EX_useRs2     <= 1'b0;
            ID_EX_regWrite   <= 1'b0;
            ID_EX_memRead    <= 1'b0;
            ID_EX_memWrite   <= 1'b0;
            ID_EX_memtoReg   <= 1'b0;
            ID_EX_aluSrc     <= 1'b0;
            ID_EX_branch     <= 1'b0;
            ID_EX_aluControl <= '0;
            ID_EX_readData1  <= '0;
            ID_EX_readData2  <= '0;
            ID_EX_signImm    <= '0;
            ID_EX_pc         <= '0;
        end else if (w_load) begin
            ID_EX_valid      <= ~w_bub;
            ID_EX_rs1        <= w_bub ? 5'd31 : IF_ID_rs1;
            ID_EX_rs2        <= w_bub ? 5'd31 : IF_ID_rs2;
            ID_EX_rd         <= w_bub ? 5'd31 : IF_ID_rd;
            ID_EX_useRs1     <= ~w_bub & IF_ID_useRs1;
            ID_EX_useRs2     <= ~w_bub & IF_ID_useRs2;
            ID_EX_regWrite   <= ~w_bub & IF_ID_regWrite;
            ID_EX_memRead    <= ~w_bub & IF_ID_memRead;
            ID_EX_memWrite   <= ~w_bub & IF_ID_memWrite;
            ID_EX_memtoReg   <= ~w_bub & IF_ID_memtoReg;
            ID_EX_aluSrc     <= ~w_bub & IF_ID_aluSrc;
            ID_EX_branch     <= ~w_bub & IF_ID_branch;
            ID_EX_aluControl <= w_bub ? '0 : IF_ID_aluControl;
            ID_EX_readData1  <= w_bub ? '0 : IF_ID_readData1;
            ID_EX_readData2  <= w_bub ? '0 : IF_ID_readData2;
            ID_EX_signImm    <= w_bub ? '0 : IF_ID_signImm;
            ID_EX_pc         <= w_bub ? '0 : IF_ID_pc;
        end
    end

`ifdef HAZARD_STATS_EN
    // saturating counts of load-use bubbles and flush bubbles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bubble_count <= '0;
            flush_count  <= '0;
        end else begin
            if (~flush & ~hold & w_lu & ~&bubble_count) bubble_count <= bubble_count + 1'b1;
            if (flush & ~&flush_count) flush_count <= flush_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of capture, load-use bubbles, flush, hold and reset
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        IF_ID_valid;
    logic [4:0]  IF_ID_rs1, IF_ID_rs2, IF_ID_rd;
    logic        IF_ID_useRs1, IF_ID_useRs2;
    logic        IF_ID_regWrite, IF_ID_memRead, IF_ID_memWrite, IF_ID_memtoReg, IF_ID_aluSrc, IF_ID_branch;
    logic [3:0]  IF_ID_aluControl;
    logic [63:0] IF_ID_readData1, IF_ID_readData2, IF_ID_signImm, IF_ID_pc;
    logic        flush, hold;
    logic        ID_EX_valid;
    logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic        ID_EX_useRs1, ID_EX_useRs2;
    logic        ID_EX_regWrite, ID_EX_memRead, ID_EX_memWrite, ID_EX_memtoReg, ID_EX_aluSrc, ID_EX_branch;
    logic [3:0]  ID_EX_aluControl;
    logic [63:0] ID_EX_readData1, ID_EX_readData2, ID_EX_signImm, ID_EX_pc;
    logic        stall;
`ifdef HAZARD_STATS_EN
    logic [3:0]  bubble_count, flush_count;
`endif
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    id_ex_stage #(
        .N(64)
`ifdef HAZARD_STATS_EN
        , .CNT_W(4)
`endif
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .IF_ID_valid(IF_ID_valid), .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2), .IF_ID_rd(IF_ID_rd),
        .IF_ID_useRs1(IF_ID_useRs1), .IF_ID_useRs2(IF_ID_useRs2),
        .IF_ID_regWrite(IF_ID_regWrite), .IF_ID_memRead(IF_ID_memRead), .IF_ID_memWrite(IF_ID_memWrite),
        .IF_ID_memtoReg(IF_ID_memtoReg), .IF_ID_aluSrc(IF_ID_aluSrc), .IF_ID_branch(IF_ID_branch),
        .IF_ID_aluControl(IF_ID_aluControl), .IF_ID_readData1(IF_ID_readData1), .IF_ID_readData2(IF_ID_readData2),
        .IF_ID_signImm(IF_ID_signImm), .IF_ID_pc(IF_ID_pc), .flush(flush), .hold(hold),
        .ID_EX_valid(ID_EX_valid), .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
        .ID_EX_useRs1(ID_EX_useRs1), .ID_EX_useRs2(ID_EX_useRs2),
        .ID_EX_regWrite(ID_EX_regWrite), .ID_EX_memRead(ID_EX_memRead), .ID_EX_memWrite(ID_EX_memWrite),
        .ID_EX_memtoReg(ID_EX_memtoReg), .ID_EX_aluSrc(ID_EX_aluSrc), .ID_EX_branch(ID_EX_branch),
        .ID_EX_aluControl(ID_EX_aluControl), .ID_EX_readData1(ID_EX_readData1), .ID_EX_readData2(ID_EX_readData2),
        .ID_EX_signImm(ID_EX_signImm), .ID_EX_pc(ID_EX_pc),
`ifdef HAZARD_STATS_EN
        .bubble_count(bubble_count), .flush_count(flush_count),
`endif
        .stall(stall)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic u1, input logic u2, input logic mr);
        IF_ID_valid = v;
        IF_ID_rs1 = rs1;
        IF_ID_rs2 = rs2;
        IF_ID_rd = rd;
        IF_ID_useRs1 = u1;
        IF_ID_useRs2 = u2;
        IF_ID_regWrite = 1'b1;
        IF_ID_memRead = mr;
        IF_ID_memWrite = 1'b0;
        IF_ID_memtoReg = mr;
        IF_ID_aluSrc = mr;
        IF_ID_branch = 1'b0;
        IF_ID_aluControl = 4'h2;
        IF_ID_readData1 = 64'h1000 + 64'(rd);
        IF_ID_readData2 = 64'h2000 + 64'(rd);
        IF_ID_signImm = 64'h30 + 64'(rd);
        IF_ID_pc = 64'h400 + 64'(rd);
    endtask

    initial begin
        reset_n = 1'b0;
        flush = 1'b0;
        hold = 1'b0;
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1);
        #12;
        check("reset_valid", 64'(ID_EX_valid), 64'd0);
        check("reset_rd", 64'(ID_EX_rd), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        tick();
        reset_n = 1'b1;

        // LDUR X3 then dependent ADD
        set_id(1'b1, 5'd1, 5'd31, 5'd3, 1'b1, 1'b0, 1'b1);
        tick();
        check("ld_rd", 64'(ID_EX_rd), 64'd3);
        check("ld_memRead", 64'(ID_EX_memRead), 64'd1);
        check("ld_data1", ID_EX_readData1, 64'h1003);
        set_id(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0);
        #1;
        check("lu_stall", 64'(stall), 64'd1);
        tick();
        check("bub_valid", 64'(ID_EX_valid), 64'd0);
        check("bub_rd", 64'(ID_EX_rd), 64'd31);
        check("bub_rs1", 64'(ID_EX_rs1), 64'd31);
        check("bub_regWrite", 64'(ID_EX_regWrite), 64'd0);
        check("bub_data1", ID_EX_readData1, 64'd0);
        check("after_bub_stall", 64'(stall), 64'd0);
`ifdef HAZARD_STATS_EN
        check("bub_count1", 64'(bubble_count), 64'd1);
`endif
        tick();
        check("add_valid", 64'(ID_EX_valid), 64'd1);
        check("add_rs1", 64'(ID_EX_rs1), 64'd3);
        check("add_rd", 64'(ID_EX_rd), 64'd5);

        // LDUR XZR then consumer of X31
        set_id(1'b1, 5'd1, 5'd2, 5'd31, 1'b1, 1'b0, 1'b1);
        tick();
        set_id(1'b1, 5'd31, 5'd31, 5'd6, 1'b1, 1'b1, 1'b0);
        #1;
        check("xzr_stall", 64'(stall), 64'd0);
        tick();
        check("xzr_valid", 64'(ID_EX_valid), 64'd1);
        check("xzr_rs1", 64'(ID_EX_rs1), 64'd31);

        // flush beats load-use
        set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1);
        tick();
        set_id(1'b1, 5'd8, 5'd7, 5'd9, 1'b1, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        check("flush_stall", 64'(stall), 64'd0);
        tick();
        flush = 1'b0;
        check("flush_valid", 64'(ID_EX_valid), 64'd0);
        check("flush_rd", 64'(ID_EX_rd), 64'd31);
`ifdef HAZARD_STATS_EN
        check("flush_count1", 64'(flush_count), 64'd1);
        check("flush_bub_count", 64'(bubble_count), 64'd1);
`endif

        // hold for three cycles with changing inputs
        set_id(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0);
        tick();
        check("pre_hold_rd", 64'(ID_EX_rd), 64'd10);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 5'd1, 5'd2, 5'(11 + i), 1'b1, 1'b1, 1'b0);
            #1;
            check("hold_stall", 64'(stall), 64'd1);
            tick();
            check("hold_rd", 64'(ID_EX_rd), 64'd10);
            check("hold_data1", ID_EX_readData1, 64'h100a);
        end
        hold = 1'b0;
        #1;
        check("release_stall", 64'(stall), 64'd0);
        tick();
        check("release_rd", 64'(ID_EX_rd), 64'd13);

        // hold together with load-use
        set_id(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0, 1'b1);
        tick();
        set_id(1'b1, 5'd12, 5'd2, 5'd14, 1'b1, 1'b1, 1'b0);
        hold = 1'b1;
        #1;
        check("hold_lu_stall", 64'(stall), 64'd1);
        tick();
        check("hold_lu_rd", 64'(ID_EX_rd), 64'd12);
        check("hold_lu_memRead", 64'(ID_EX_memRead), 64'd1);
        hold = 1'b0;
        #1;
        check("hold_lu_stall2", 64'(stall), 64'd1);
        tick();
        check("hold_lu_bub", 64'(ID_EX_valid), 64'd0);
`ifdef HAZARD_STATS_EN
        check("bub_count2", 64'(bubble_count), 64'd2);
`endif
        tick();
        check("hold_lu_rs1", 64'(ID_EX_rs1), 64'd12);

        // invalid ID instruction: control zeroed, not counted
        set_id(1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0);
        tick();
        check("inv_valid", 64'(ID_EX_valid), 64'd0);
        check("inv_regWrite", 64'(ID_EX_regWrite), 64'd0);
`ifdef HAZARD_STATS_EN
        check("inv_bub_count", 64'(bubble_count), 64'd2);
`endif

        // reset in the middle of a stall
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1);
        tick();
        set_id(1'b1, 5'd3, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);
        #1;
        check("pre_rst_stall", 64'(stall), 64'd1);
        reset_n = 1'b0;
        #1;
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_memRead", 64'(ID_EX_memRead), 64'd0);
        check("rst_data1", ID_EX_readData1, 64'd0);
`ifdef HAZARD_STATS_EN
        check("rst_bub_count", 64'(bubble_count), 64'd0);
        check("rst_flush_count", 64'(flush_count), 64'd0);
`endif
        tick();
        reset_n = 1'b1;

`ifdef HAZARD_STATS_EN
        // twenty load-use bubbles saturate a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1);
            tick();
            set_id(1'b1, 5'd3, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);
            tick();
            tick();
        end
        check("sat_bub_count", 64'(bubble_count), 64'd15);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the five-stage LEGv8 core, with integrated load-use hazard detection, bubble insertion and branch flush. It captures decoded operands and control from the ID stage each cycle. It presents the registered register numbers (ID_EX_rs1/rs2/rd) and control signals to the EX stage and the forwarding unit. It drives the stall request that freezes the PC and the IF/ID register.

## Interface
- N, 64, datapath width (operands, immediate, PC)
- CNT_W, 32, width of the hazard statistics counters (HAZARD_STATS_EN only)

- clk  in  1  pipeline clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- IF_ID_valid  in  1  ID stage holds a real instruction
- IF_ID_rs1, IF_ID_rs2, IF_ID_rd  in  5 each  decoded register numbers
- IF_ID_useRs1, IF_ID_useRs2  in  1 each  instruction actually reads that source
- IF_ID_regWrite, IF_ID_memRead, IF_ID_memWrite, IF_ID_memtoReg, IF_ID_aluSrc, IF_ID_branch  in  1 each  decoded control
- IF_ID_aluControl  in  4  ALU operation
- IF_ID_readData1, IF_ID_readData2, IF_ID_signImm, IF_ID_pc  in  N each  operands, immediate, PC
- flush  in  1  taken branch resolved downstream; kill the instruction in ID
- hold  in  1  external freeze (memory wait); ID/EX keeps its contents
- ID_EX_*  out  same widths as inputs  registered copies of every IF_ID_* field (valid, rs1, rs2, rd, control, data)
- stall  out  1  combinational; freeze PC and IF/ID this cycle
- bubble_count, flush_count  out  CNT_W each  statistics (HAZARD_STATS_EN only)

## Operation
- Load-use hazard (combinational): lu = ID_EX_valid & ID_EX_memRead & (ID_EX_rd != 31) & IF_ID_valid & ((IF_ID_useRs1 & IF_ID_rs1 == ID_EX_rd) | (IF_ID_useRs2 & IF_ID_rs2 == ID_EX_rd)).
- Register 31 (XZR) never creates a hazard.
- stall = (lu | hold) & ~flush.
- Per-edge update, highest priority first:
  - reset_n low: all ID_EX_* outputs 0, counters 0.
  - flush: load a bubble.
  - hold: keep all ID_EX_* unchanged.
  - lu: load a bubble.
  - Otherwise: capture all IF_ID_* fields.
- Bubble: ID_EX_valid, regWrite, memRead, memWrite, memtoReg and branch all 0. rs1, rs2 and rd are forced to 31 so downstream forwarding never matches. Data fields, aluSrc and aluControl are don't-care and are driven to 0.
- IF_ID_valid = 0 is captured as-is: control is zeroed, same as a bubble, but it is not counted.

## Timing
- Latency: one cycle from ID inputs to ID_EX_* outputs.
- stall is valid in the same cycle as the hazardous ID instruction. The load advances to MEM on that edge, so lu deasserts the next cycle. A single load-use costs exactly one bubble.
- Back-to-back dependent loads give one bubble per load.
- Simultaneous flush and lu: the flush wins. One bubble is loaded, stall = 0 and the ID instruction is discarded upstream.
- Simultaneous hold and lu: the register is held and stall = 1. The bubble is inserted on the first edge with hold low, if lu still holds.
- Reset mid-stall: outputs clear asynchronously and stall = 0 while reset_n is low.
- All outputs are 0 during and after reset.

## Configuration
- HAZARD_STATS_EN defined:
  - bubble_count increments on every edge that loads a bubble due to lu.
  - flush_count increments on every edge that loads a bubble due to flush.
  - Both counters saturate at 2^CNT_W-1 and clear on reset.
- HAZARD_STATS_EN undefined: both counter ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset: assert reset_n = 0 mid-operation → every ID_EX_* and counter is 0 immediately; stall = 0.
- Load-use:
  - Stimulus: ID_EX holds LDUR X3 (memRead = 1, rd = 3); ID holds ADD with rs1 = 3, useRs1 = 1.
  - Required: stall = 1 that cycle. Next cycle ID_EX_valid = 0, ID_EX_rd = 31, bubble_count = 1. The following cycle the ADD is captured with ID_EX_rs1 = 3.
- XZR load: LDUR XZR followed by a consumer with rs1 = 31 → stall = 0, no bubble.
- Flush priority: lu and flush both high → stall = 0; next cycle a bubble is loaded, flush_count = 1 and bubble_count is unchanged.
- Hold:
  - Stimulus: hold = 1 for 3 cycles while the IF_ID_* inputs change.
  - Required: ID_EX_* stays constant and stall = 1 throughout. On release, the current inputs are captured.
- Saturation: with HAZARD_STATS_EN and CNT_W = 4, force 20 load-use bubbles → bubble_count stops at 15.
